// File: rtl/led_game_pkg.sv
// led_game_pkg
// Shared definitions for the LED round scheduler: FSM state encoding,
// LFSR seed/taps, game limits, the BCD score type and small helpers.
package led_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHOW  = 3'd2,
        ST_HIT   = 3'd3,
        ST_MISS  = 3'd4,
        ST_CLEAR = 3'd5,
        ST_OVER  = 3'd6
    } game_state_e;

    // x^10 + x^7 + 1 : feedback taken from bits 9 and 6.
    localparam logic [9:0] LFSR_SEED = 10'h2A5;
    localparam logic [9:0] LFSR_TAPS = 10'h240;

    localparam logic [1:0] INIT_LIVES     = 2'd3;
    localparam logic [2:0] MAX_LEVEL      = 3'd4;
    localparam logic [2:0] HITS_PER_LEVEL = 3'd5;
    localparam int         MAX_SCORE      = 99;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_score_t;

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], ^(v & LFSR_TAPS)};
    endfunction

    // BCD increment that sticks at MAX_SCORE.
    function automatic bcd_score_t bcd_inc_sat(input bcd_score_t s);
        bcd_score_t r;
        r = s;
        if (s.tens == 4'(MAX_SCORE / 10) && s.ones == 4'(MAX_SCORE % 10)) begin
            r = s;
        end else if (s.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = s.tens + 4'd1;
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_round_scheduler_if.sv
// led_round_scheduler_if
// Player/game signal bundle of the LED round scheduler.
//   start      : game start request (edge-detected inside the scheduler)
//   switch     : player switch vector
//   led        : target pattern shown to the player
//   score_tens, score_ones : BCD score digits
//   level, lives          : game progress
//   hit, miss             : one-cycle result pulses
//   game_over             : high while in OVER
//   state                 : FSM state encoding for debug
// There is no valid/ready handshake: inputs are sampled on every rising
// clock edge and outputs are valid in every cycle.
interface led_round_scheduler_if;
    logic       start;
    logic [9:0] switch;
    logic [9:0] led;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [2:0] level;
    logic [1:0] lives;
    logic       hit;
    logic       miss;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output start, switch,
        input  led, score_tens, score_ones, level, lives, hit, miss, game_over, state
    );

    modport slave (
        input  start, switch,
        output led, score_tens, score_ones, level, lives, hit, miss, game_over, state
    );
endinterface

// File: rtl/led_round_scheduler_tick_divider.sv
// tick_divider
// Free-running divider producing a one-cycle tick every TICK_DIV cycles.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clear   : restart the count so the next tick is TICK_DIV cycles away
//   tick    : one-cycle pulse
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/led_round_scheduler.sv
// led_round_scheduler
// Reaction game round scheduler: shows an LFSR pattern on the LEDs for a
// level-dependent window of ticks, scores a hit when the player matches it
// with the switches, costs a life when the window expires.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : led_round_scheduler_if.slave (start/switch in, game outputs out)
module led_round_scheduler
    import led_game_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int BASE_WINDOW = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    led_round_scheduler_if.slave  bus
);
    localparam int TW = $clog2(BASE_WINDOW) + 1;

    game_state_e state_q, state_d;
    logic        start_q;
    logic        armed_q;
    logic [9:0]  lfsr_q, lfsr_d;
    logic [9:0]  pattern_q, pattern_d;
    bcd_score_t  score_q, score_d;
    logic [2:0]  level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  hits_q, hits_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    logic          tick;
    logic          start_rise;
    logic          match;
    logic          expire;
    logic [TW-1:0] window;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == ST_LOAD),
        .tick    (tick)
    );

    // armed_q stays low for the first edge after reset, so a start held high
    // across reset release never looks like a rising edge.
    assign start_rise = bus.start && !start_q && armed_q;
    assign match      = (bus.switch == pattern_q);
    assign window     = TW'(BASE_WINDOW) >> level_q;
    // Expiry is the cycle in which the window-th tick of this round arrives.
    assign expire     = tick && (tick_cnt_q == window - TW'(1));

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        pattern_d  = pattern_q;
        score_d    = score_q;
        level_d    = level_q;
        lives_d    = lives_q;
        hits_d     = hits_q;
        tick_cnt_d = tick_cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_LOAD;
                    score_d = '0;
                    level_d = 3'd0;
                    lives_d = INIT_LIVES;
                    hits_d  = 3'd0;
                end
            end
            ST_LOAD: begin
                lfsr_d     = lfsr_next(lfsr_q);
                pattern_d  = lfsr_d;
                tick_cnt_d = '0;
                state_d    = ST_SHOW;
            end
            ST_SHOW: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
                // A match beats a simultaneous expiry.
                if (match) begin
                    state_d = ST_HIT;
                    score_d = bcd_inc_sat(score_q);
                    if (hits_q == HITS_PER_LEVEL - 3'd1) begin
                        hits_d = 3'd0;
                        if (level_q < MAX_LEVEL) begin
                            level_d = level_q + 3'd1;
                        end
                    end else begin
                        hits_d = hits_q + 3'd1;
                    end
                end else if (expire) begin
                    state_d = ST_MISS;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            ST_HIT: begin
                state_d = ST_CLEAR;
            end
            ST_MISS: begin
                state_d = (lives_q == 2'd0) ? ST_OVER : ST_CLEAR;
            end
            ST_CLEAR: begin
                if (bus.switch == 10'h000) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            armed_q    <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            pattern_q  <= 10'h000;
            score_q    <= '0;
            level_q    <= 3'd0;
            lives_q    <= INIT_LIVES;
            hits_q     <= 3'd0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.start;
            armed_q    <= 1'b1;
            lfsr_q     <= lfsr_d;
            pattern_q  <= pattern_d;
            score_q    <= score_d;
            level_q    <= level_d;
            lives_q    <= lives_d;
            hits_q     <= hits_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        bus.led = 10'h000;
        case (state_q)
            ST_SHOW, ST_HIT, ST_MISS: bus.led = pattern_q;
            ST_OVER:                  bus.led = 10'h3FF;
            default:                  bus.led = 10'h000;
        endcase
    end

    assign bus.score_tens = score_q.tens;
    assign bus.score_ones = score_q.ones;
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.hit        = (state_q == ST_HIT);
    assign bus.miss       = (state_q == ST_MISS);
    assign bus.game_over  = (state_q == ST_OVER);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_led_round_scheduler.sv
// tb_led_round_scheduler
// Directed self-checking bench for led_round_scheduler with TICK_DIV=2.
module tb_led_round_scheduler;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_SHOW  = 2;
    localparam int S_HIT   = 3;
    localparam int S_MISS  = 4;
    localparam int S_CLEAR = 5;
    localparam int S_OVER  = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    led_round_scheduler_if bus ();

    led_round_scheduler #(.TICK_DIV(2), .BASE_WINDOW(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int         score_m;
    int         level_m;
    int         lives_m;
    int         hits_m;
    logic [9:0] lfsr_m;
    logic [9:0] pat_m;

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_progress(input string tag);
        check_eq({tag, "_tens"},  32'(bus.score_tens), score_m / 10);
        check_eq({tag, "_ones"},  32'(bus.score_ones), score_m % 10);
        check_eq({tag, "_level"}, 32'(bus.level), level_m);
        check_eq({tag, "_lives"}, 32'(bus.lives), lives_m);
    endtask

    task automatic load_to_show();
        check_eq("load_state", 32'(bus.state), S_LOAD);
        check_eq("load_led", 32'(bus.led), 0);
        lfsr_m = lfsr_step(lfsr_m);
        pat_m  = lfsr_m;
        step();
        check_eq("show_state", 32'(bus.state), S_SHOW);
        check_eq("show_led", 32'(bus.led), 32'(pat_m));
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        check_eq("start_state", 32'(bus.state), S_LOAD);
        score_m = 0;
        level_m = 0;
        lives_m = 3;
        hits_m  = 0;
        check_progress("start");
        bus.start = 1'b0;
        load_to_show();
    endtask

    task automatic do_hit(input int dly, input int hold);
        repeat (dly) begin
            step();
            check_eq("show_wait", 32'(bus.state), S_SHOW);
        end
        bus.switch = pat_m;
        step();
        if (score_m < 99) score_m++;
        hits_m++;
        if (hits_m == 5) begin
            hits_m = 0;
            if (level_m < 4) level_m++;
        end
        check_eq("hit_state", 32'(bus.state), S_HIT);
        check_eq("hit_pulse", 32'(bus.hit), 1);
        check_eq("hit_no_miss", 32'(bus.miss), 0);
        check_progress("hit");
        step();
        check_eq("clear_state", 32'(bus.state), S_CLEAR);
        check_eq("clear_hit_low", 32'(bus.hit), 0);
        check_eq("clear_led", 32'(bus.led), 0);
        repeat (hold) begin
            step();
            check_eq("clear_hold", 32'(bus.state), S_CLEAR);
        end
        bus.switch = 10'h000;
        step();
        load_to_show();
    endtask

    task automatic do_miss(input int exp_cycles);
        int n;
        n = 0;
        bus.switch = 10'h000;
        while (bus.state == 3'(S_SHOW) && n < 200) begin
            step();
            n++;
        end
        check_eq("miss_window", n, exp_cycles);
        lives_m--;
        check_eq("miss_state", 32'(bus.state), S_MISS);
        check_eq("miss_pulse", 32'(bus.miss), 1);
        check_eq("miss_no_hit", 32'(bus.hit), 0);
        check_eq("miss_led", 32'(bus.led), 32'(pat_m));
        check_progress("miss");
        step();
        if (lives_m == 0) begin
            check_eq("over_state", 32'(bus.state), S_OVER);
            check_eq("over_flag", 32'(bus.game_over), 1);
            check_eq("over_led", 32'(bus.led), 32'h3FF);
            repeat (3) step();
            check_eq("over_hold", 32'(bus.state), S_OVER);
            check_progress("over_hold");
        end else begin
            check_eq("miss_clear", 32'(bus.state), S_CLEAR);
            step();
            load_to_show();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(bus.state), S_IDLE);
        check_eq({tag, "_led"},   32'(bus.led), 0);
        check_eq({tag, "_tens"},  32'(bus.score_tens), 0);
        check_eq({tag, "_ones"},  32'(bus.score_ones), 0);
        check_eq({tag, "_level"}, 32'(bus.level), 0);
        check_eq({tag, "_lives"}, 32'(bus.lives), 3);
        check_eq({tag, "_hit"},   32'(bus.hit), 0);
        check_eq({tag, "_miss"},  32'(bus.miss), 0);
        check_eq({tag, "_over"},  32'(bus.game_over), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.switch = 10'h000;
        lfsr_m     = 10'h2A5;
        score_m = 0; level_m = 0; lives_m = 3; hits_m = 0;

        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        step();
        step();
        check_eq("idle_after_reset", 32'(bus.state), S_IDLE);

        // First round: first pattern is next(2A5) = 14B by hand.
        do_start();
        check_eq("first_pattern", 32'(bus.led), 32'h14B);

        // Hit after 3 SHOW cycles, CLEAR held while switches stay up.
        do_hit(3, 2);

        // Three misses at level 0 end the game.
        do_miss(32);
        do_miss(32);
        do_miss(32);

        // Restart from OVER, five quick hits reach level 1.
        do_start();
        for (int i = 0; i < 5; i++) do_hit(0, 0);
        check_eq("level_after_5", 32'(bus.level), 1);
        do_miss(16);

        // Push score past 99 and level past 4.
        for (int i = 0; i < 95; i++) do_hit(0, 0);
        check_eq("score_sat_tens", 32'(bus.score_tens), 9);
        check_eq("score_sat_ones", 32'(bus.score_ones), 9);
        check_eq("level_sat", 32'(bus.level), 4);
        do_miss(2);

        // Match exactly on the expiry cycle of a 1-tick window.
        do_hit(1, 0);

        // Reset mid-SHOW with start held high through release.
        step();
        #2;
        reset_n   = 1'b0;
        bus.start = 1'b1;
        #1;
        check_reset_values("midreset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("release_idle", 32'(bus.state), S_IDLE);
            check_eq("release_no_hit", 32'(bus.hit), 0);
        end
        bus.start = 1'b0;
        step();
        lfsr_m = 10'h2A5;
        do_start();
        check_eq("pattern_after_reset", 32'(bus.led), 32'h14B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_round_scheduler.md
LED_ROUND_SCHEDULER -- requirements
Module: led_round_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000: clock cycles per game tick, legal range >= 2.
REQ-002 Parameter BASE_WINDOW, default 16: SHOW window in ticks at level 0, power of two, legal range >= 16.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  game start request, active-high, acted on at its synchronous rising edge only.
REQ-006 switch  in  10  player switch vector.
REQ-007 led  out  10  target pattern shown to the player.
REQ-008 score_tens, score_ones  out  4 each  BCD score digits, 00..99.
REQ-009 level  out  3  current level, 0..4.
REQ-010 lives  out  2  remaining lives, 0..3.
REQ-011 hit, miss  out  1 each  one-cycle result pulses.
REQ-012 game_over  out  1  high while in OVER.
REQ-013 state  out  3  current FSM state encoding, for debug and bench.

Function
REQ-014 The FSM SHALL use states IDLE=0, LOAD=1, SHOW=2, HIT=3, MISS=4, CLEAR=5, OVER=6.
REQ-015 IDLE and OVER SHALL move to LOAD on a start rising edge, and that same edge SHALL clear score to 00, set level to 0, set lives to 3 and clear the hit-in-level count.
REQ-016 start edges in any state other than IDLE and OVER SHALL be ignored.
REQ-017 LOAD SHALL last exactly 1 cycle: it advances the 10-bit LFSR (x^10+x^7+1, seed 10'h2A5), latches the LFSR value as the pattern, clears the tick counter, and moves to SHOW.
REQ-018 led SHALL equal the latched pattern in SHOW, HIT and MISS, and SHALL be 10'h000 in all other states except OVER, where it SHALL be 10'h3FF.
REQ-019 SHOW window = BASE_WINDOW >> level ticks (16, 8, 4, 2, 1 at the default); the tick counter SHALL start at 0 on entry to SHOW.
REQ-020 In SHOW, switch == pattern SHALL cause a move to HIT on the next edge.
REQ-021 In SHOW, expiry of the window SHALL cause a move to MISS on the next edge.
REQ-022 If a switch match and window expiry occur in the same cycle, HIT SHALL win.
REQ-023 On the SHOW->HIT edge, score SHALL increment in BCD and saturate at 99; the hit-in-level count SHALL increment, and when it reaches 5 it SHALL reset to 0 and level SHALL increment, saturating at 4.
REQ-024 HIT SHALL last 1 cycle with hit=1, then move to CLEAR; the new score SHALL be visible in the same cycle as hit.
REQ-025 On the SHOW->MISS edge, lives SHALL decrement.
REQ-026 MISS SHALL last 1 cycle with miss=1, then move to OVER if lives==0, else to CLEAR.
REQ-027 CLEAR SHALL wait until switch==10'h000 and then move to LOAD; if switch is already 0, CLEAR SHALL last exactly 1 cycle.
REQ-028 OVER SHALL hold score, level and lives until a start rising edge.
REQ-029 hit and miss SHALL never be high in the same cycle.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, led 0, score 00, level 0, lives 3, hit 0, miss 0, game_over 0, LFSR 10'h2A5, tick and cycle counters 0, start edge detector 0.
REQ-031 Reset asserted mid-game SHALL abandon the round without producing any hit or miss pulse.
REQ-032 Reset release SHALL NOT be treated as a start edge, even if start is high.

Structure
REQ-033 Shared package led_game_pkg SHALL hold: state encoding, LFSR seed and taps, INIT_LIVES=3, MAX_LEVEL=4, HITS_PER_LEVEL=5, MAX_SCORE=99.
REQ-034 Sub-module tick_divider (clock, reset_n, clear) SHALL produce a one-cycle tick every TICK_DIV cycles; the scheduler SHALL drive clear on LOAD.

Verification (TICK_DIV=2)
REQ-035 Reset, then start pulse -> state goes 0->1->2, led=pattern, score 00, lives 3.
REQ-036 Drive switch=led 3 cycles into SHOW -> hit=1 for 1 cycle with score 01; then CLEAR holds until switch=0, then LOAD.
REQ-037 Never match in SHOW -> miss after 16 ticks (32 cycles) at level 0 and lives 2; three misses -> OVER, game_over=1, led=3FF.
REQ-038 5 consecutive hits -> level 1, next window 8 ticks; 100 hits -> score saturates at 99, level saturates at 4 (window 1 tick).
REQ-039 Switch match on the expiry cycle -> hit, no miss.
REQ-040 Assert reset_n=0 mid-SHOW -> all outputs return to reset values immediately; start high during reset release -> state stays IDLE.
